// File: rtl/i2c_req_arbiter_if.sv
// Bundle of the two requester ports and the I2C master control-unit handshake.
// The arbiter connects through 'slave'; the environment (requesters plus master) uses 'master'.
interface i2c_req_arbiter_if;
    logic        Req0, Req1;
    logic        Rw0, Rw1;
    logic [7:0]  Ptr0, Ptr1;
    logic        SetPtr0, SetPtr1;
    logic [15:0] Wdata0, Wdata1;
    logic        Gnt0, Gnt1;
    logic        Done0, Done1;
    logic        Err_out;
    logic [15:0] Rdata;

    logic        M_Ready, M_Data_valid, M_Error, M_Repeat;
    logic [7:0]  M_Data_out;
    logic        M_Start, M_R_W, M_Set_pointer, M_Return;
    logic [7:0]  M_Pointer;
    logic [15:0] M_Wdata;

    modport slave (
        input  Req0, Req1, Rw0, Rw1, Ptr0, Ptr1, SetPtr0, SetPtr1, Wdata0, Wdata1,
        output Gnt0, Gnt1, Done0, Done1, Err_out, Rdata,
        input  M_Ready, M_Data_valid, M_Error, M_Repeat, M_Data_out,
        output M_Start, M_R_W, M_Set_pointer, M_Return, M_Pointer, M_Wdata
    );

    modport master (
        output Req0, Req1, Rw0, Rw1, Ptr0, Ptr1, SetPtr0, SetPtr1, Wdata0, Wdata1,
        input  Gnt0, Gnt1, Done0, Done1, Err_out, Rdata,
        output M_Ready, M_Data_valid, M_Error, M_Repeat, M_Data_out,
        input  M_Start, M_R_W, M_Set_pointer, M_Return, M_Pointer, M_Wdata
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin front end for an I2C master control unit: grants one
// requester, launches its transaction, collects up to two read bytes and reports completion.
module i2c_req_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic             Clk,
    input  logic             Rst,
    i2c_req_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, BUSY, DONE} state_t;

    state_t      state;
    logic        sel;
    logic        last;
    logic [1:0]  gnt_q;
    logic [1:0]  done_q;
    logic        err_out_q;
    logic        start_q;
    logic        rw_q;
    logic        setptr_q;
    logic [7:0]  ptr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic [15:0] tmo;
    logic        err;
    logic [1:0]  nbytes;
    logic        dv_q;
    logic        rdy_q;

    logic [1:0]  req;
    logic        win;
    logic        active;
    logic [15:0] tmo_nxt;
    logic        tmo_hit;
    logic        err_nxt;
    logic        dv_rise;
    logic        rdy_rise;
    logic        fin;
    logic        fin_err;

    assign req = {bus.Req1, bus.Req0};

    // On a tie the requester not served last wins; otherwise the single requester wins.
    always_comb begin
        win = 1'b0;
        if (req == 2'b11) win = ~last;
        else              win = req[1];
    end

    assign active   = (state == LAUNCH) || (state == WAIT_BUSY) || (state == BUSY);
    assign tmo_nxt  = tmo + 16'd1;
    assign tmo_hit  = active && (tmo_nxt == TIMEOUT);
    assign err_nxt  = err | (bus.M_Error & ((state == WAIT_BUSY) || (state == BUSY)));
    assign dv_rise  = bus.M_Data_valid & ~dv_q;
    assign rdy_rise = bus.M_Ready & ~rdy_q;
    assign fin      = tmo_hit || ((state == BUSY) && rdy_rise);
    assign fin_err  = err_nxt | tmo_hit;

    assign bus.Gnt0          = gnt_q[0];
    assign bus.Gnt1          = gnt_q[1];
    assign bus.Done0         = done_q[0];
    assign bus.Done1         = done_q[1];
    assign bus.Err_out       = err_out_q;
    assign bus.Rdata         = rdata_q;
    assign bus.M_Start       = start_q;
    assign bus.M_R_W         = rw_q;
    assign bus.M_Set_pointer = setptr_q;
    assign bus.M_Pointer     = ptr_q;
    assign bus.M_Wdata       = wdata_q;
    // Repeated-start handoff back to the master is only meaningful for pointer-set reads.
    assign bus.M_Return      = (state == BUSY) & bus.M_Repeat & setptr_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_out_q <= 1'b0;
            start_q   <= 1'b0;
            rw_q      <= 1'b0;
            setptr_q  <= 1'b0;
            ptr_q     <= 8'h00;
            wdata_q   <= 16'h0000;
            rdata_q   <= 16'h0000;
            tmo       <= 16'h0000;
            err       <= 1'b0;
            nbytes    <= 2'd0;
            dv_q      <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            dv_q  <= bus.M_Data_valid;
            rdy_q <= bus.M_Ready;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel      <= win;
                        last     <= win;
                        gnt_q    <= win ? 2'b10 : 2'b01;
                        rw_q     <= win ? bus.Rw1     : bus.Rw0;
                        setptr_q <= win ? bus.SetPtr1 : bus.SetPtr0;
                        ptr_q    <= win ? bus.Ptr1    : bus.Ptr0;
                        wdata_q  <= win ? bus.Wdata1  : bus.Wdata0;
                        rdata_q  <= 16'h0000;
                        tmo      <= 16'h0000;
                        err      <= 1'b0;
                        nbytes   <= 2'd0;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo <= tmo_nxt;
                    if (bus.M_Ready) begin
                        start_q <= 1'b1;
                        state   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    tmo <= tmo_nxt;
                    err <= err_nxt;
                    if (!bus.M_Ready) begin
                        start_q <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    tmo <= tmo_nxt;
                    err <= err_nxt;
                    if (bus.M_Repeat) rw_q <= 1'b1;
                    // Only the first two data-valid edges carry payload; later ones are dropped.
                    if (dv_rise) begin
                        if (nbytes == 2'd0) begin
                            rdata_q[15:8] <= bus.M_Data_out;
                            nbytes        <= 2'd1;
                        end else if (nbytes == 2'd1) begin
                            rdata_q[7:0]  <= bus.M_Data_out;
                            nbytes        <= 2'd2;
                        end
                    end
                end
                DONE: begin
                    done_q    <= 2'b00;
                    err_out_q <= 1'b0;
                    gnt_q     <= 2'b00;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Completion (normal or timeout) overrides whatever the state branch scheduled.
            if (fin) begin
                state     <= DONE;
                start_q   <= 1'b0;
                done_q    <= sel ? 2'b10 : 2'b01;
                err_out_q <= fin_err;
                err       <= fin_err;
            end
        end
    end
endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Parameters
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000, meaning the maximum number of Clk cycles one transaction may take before it is aborted.

Interface
REQ-002 SHALL have port Clk, input, 1, system clock; all state updates on posedge Clk.
REQ-003 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports Req0/Req1, input, 1 each; a transaction request is held high until the matching Done pulse.
REQ-005 SHALL have ports Rw0/Rw1, input, 1 each; 1 = read, 0 = write.
REQ-006 SHALL have ports Ptr0/Ptr1, input, 8 each; the sensor pointer byte.
REQ-007 SHALL have ports SetPtr0/SetPtr1, input, 1 each; 1 = pointer-set write followed by a repeated-start read.
REQ-008 SHALL have ports Wdata0/Wdata1, input, 16 each; write payload, MSB byte in [15:8].
REQ-009 SHALL have ports Gnt0/Gnt1, output, 1 each; requester currently owns the master.
REQ-010 SHALL have ports Done0/Done1, output, 1 each; one-cycle completion pulse.
REQ-011 SHALL have port Err_out, output, 1; valid only while a Done pulse is high; 1 = NACK, error, or timeout.
REQ-012 SHALL have port Rdata, output, 16; read result, valid from the Done pulse until the next grant.
REQ-013 SHALL have ports M_Ready, M_Data_valid, M_Error, M_Repeat, input, 1 each; status from the I2C master control unit.
REQ-014 SHALL have port M_Data_out, input, 8; the master's received byte.
REQ-015 SHALL have ports M_Start, M_R_W, M_Set_pointer, M_Return, output, 1 each; commands to the master.
REQ-016 SHALL have port M_Pointer, output, 8; pointer byte to the master.
REQ-017 SHALL have port M_Wdata, output, 16; write payload to the master.

Function
REQ-018 SHALL implement the FSM states IDLE, LAUNCH, WAIT_BUSY, BUSY and DONE.
REQ-019 SHALL, in IDLE with any Req high, grant round-robin: if both requesters are high, grant the one not served last; if only one is high, grant it. The last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-020 SHALL, on grant, latch Rw, Ptr, SetPtr and Wdata into internal registers and drive M_R_W, M_Pointer, M_Set_pointer and M_Wdata from those registers until DONE; later changes on requester inputs are ignored.
REQ-021 SHALL assert Gnt[x] from the cycle after the grant decision through the DONE cycle inclusive.
REQ-022 SHALL, in LAUNCH, hold M_Start=1 only while M_Ready=1, and move to WAIT_BUSY in the cycle after M_Start was asserted.
REQ-023 SHALL, in WAIT_BUSY, keep M_Start=1 until M_Ready falls, then move to BUSY.
REQ-024 SHALL, in BUSY, detect rising edges of M_Data_valid: on the 1st edge capture M_Data_out into Rdata[15:8]; on the 2nd edge capture it into Rdata[7:0]. Further edges are ignored.
REQ-025 SHALL clear Rdata to 16'h0000 at each grant, so a single-byte read (Ptr[1:0]=2'b01) returns {byte,8'h00}.
REQ-026 SHALL drive M_Return=1 combinationally while in BUSY with M_Repeat=1 and latched SetPtr=1, and SHALL force M_R_W=1 from the first cycle M_Repeat is seen until DONE.
REQ-027 SHALL set a sticky error flag if M_Error=1 in any cycle of WAIT_BUSY or BUSY.
REQ-028 SHALL move from BUSY to DONE on the rising edge of M_Ready.
REQ-029 SHALL run a 16-bit timeout counter that clears on grant and increments in LAUNCH, WAIT_BUSY and BUSY; on reaching TIMEOUT it SHALL go to DONE with the error flag set and M_Start=0.
REQ-030 SHALL, in DONE, pulse Done[x] for exactly one cycle with Err_out equal to the sticky error flag, then return to IDLE; arbitration may grant in the cycle after DONE.
REQ-031 SHALL NOT sample Req while not in IDLE, and SHALL NOT abort a granted transaction if its Req drops.

Reset
REQ-032 SHALL, while Rst=0, asynchronously force:
- state = IDLE
- Gnt0/1 = 0, Done0/1 = 0, Err_out = 0
- M_Start = 0, M_Return = 0, M_R_W = 0, M_Set_pointer = 0
- M_Pointer = 8'h00, M_Wdata = 16'h0000, Rdata = 16'h0000
- timeout counter = 0, error flag = 0, last-served pointer = 1
REQ-033 SHALL, when reset is asserted mid-transaction, discard the transaction without issuing any Done pulse.

Verification
REQ-034 SHALL be checked with: Req0 read, Ptr0=8'h00; the master model returns bytes 8'h19, 8'h40 -> Done0 pulses once, Err_out=0, Rdata=16'h1940.
REQ-035 SHALL be checked with: Req0 and Req1 rising in the same cycle after reset -> Gnt0 first, then Gnt1; with both held continuously, grants alternate 0,1,0.
REQ-036 SHALL be checked with: Req1 with SetPtr1=1, Ptr1=8'h01; the model asserts M_Repeat -> M_Return=1 while M_Repeat is high, M_R_W=1, Rdata=16'hXX00 (single byte), Done1 pulses.
REQ-037 SHALL be checked with: a write where the model raises M_Error -> Done pulses with Err_out=1.
REQ-038 SHALL be checked with: M_Ready held at 1 after M_Start (no response) -> Done pulses with Err_out=1 exactly TIMEOUT cycles after grant.
REQ-039 SHALL be checked with: Rst pulsed low during BUSY -> all outputs at reset values, no Done pulse, next Req served normally.
